// File: rtl/int_vector_seq.sv
// Interrupt vectoring sequencer: arbitrates enabled requests at instruction boundaries with 8051 two-level nesting.
// Latency: int_call rises 1 cycle after the qualifying instr_end sample; clr_flag pulses 1 cycle after the ack edge.
// Backpressure: the grant is held in CALL, with int_vector and int_src stable, until cpu_ack; no new arbitration until then.
module int_vector_seq #(
  parameter logic [15:0] VEC_BASE   = 16'h0003,
  parameter logic [15:0] VEC_STRIDE = 16'h0008,
  parameter int          N_SRC      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] int_req,
  input  logic             ea,
  input  logic [N_SRC-1:0] ip,
  input  logic [1:0]       it_mode,
  input  logic             instr_end,
  input  logic             blocked,
  input  logic             cpu_ack,
  input  logic             reti,
  output logic             int_call,
  output logic [15:0]      int_vector,
  output logic [2:0]       int_src,
  output logic [N_SRC-1:0] clr_flag,
  output logic [1:0]       in_service
);

  typedef enum logic {
    IDLE = 1'b0,
    CALL = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [N_SRC-1:0]  hi_cand, lo_cand, win_set;
  logic              win_found, win_lvl;
  logic [2:0]        win_idx;
  logic [15:0]       win_vec;
  logic [2:0]        grant_idx_q;
  logic              grant_lvl_q;
  logic [15:0]       grant_vec_q;
  logic              take_grant, take_ack, clr_hit;
  logic [N_SRC-1:0]  clr_d;
  logic [1:0]        is_d;

  // Qualify candidates against the current nesting level and pick the lowest-index winner.
  always_comb begin
    hi_cand   = int_req & ip & {N_SRC{ea}};
    lo_cand   = int_req & ~ip & {N_SRC{ea}};
    win_set   = '0;
    win_found = 1'b0;
    win_lvl   = 1'b0;
    win_idx   = 3'd0;
    if (!in_service[1]) begin
      if (|hi_cand) begin
        win_set   = hi_cand;
        win_found = 1'b1;
        win_lvl   = 1'b1;
      end else if (!in_service[0] && (|lo_cand)) begin
        win_set   = lo_cand;
        win_found = 1'b1;
      end
    end
    // Scan from the top so the lowest set index is the one that sticks.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (win_set[i]) win_idx = i[2:0];
    end
    win_vec = VEC_BASE + VEC_STRIDE * {13'd0, win_idx};
  end

  // Next-state and CPU-facing outputs; outputs read as zero outside CALL.
  always_comb begin
    state_d    = state_q;
    take_grant = 1'b0;
    take_ack   = 1'b0;
    int_call   = 1'b0;
    int_vector = 16'h0000;
    int_src    = 3'd0;
    case (state_q)
      IDLE: begin
        if (instr_end && !blocked && win_found) begin
          take_grant = 1'b1;
          state_d    = CALL;
        end
      end
      CALL: begin
        int_call   = 1'b1;
        int_vector = grant_vec_q;
        int_src    = grant_idx_q;
        if (cpu_ack) begin
          take_ack = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Hardware flag clearing and in-service update; a same-cycle reti clears before the ack sets.
  always_comb begin
    case (grant_idx_q)
      3'd0:    clr_hit = it_mode[0];
      3'd1:    clr_hit = 1'b1;
      3'd2:    clr_hit = it_mode[1];
      3'd3:    clr_hit = 1'b1;
      default: clr_hit = 1'b0;
    endcase
    clr_d = (take_ack && clr_hit) ? (N_SRC'(1) << grant_idx_q) : '0;

    is_d = in_service;
    if (reti) begin
      if (in_service[1]) is_d[1] = 1'b0;
      else               is_d[0] = 1'b0;
    end
    if (take_ack) begin
      if (grant_lvl_q) is_d[1] = 1'b1;
      else             is_d[0] = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Grant latch: captured once on entry to CALL and held regardless of later request changes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_idx_q <= 3'd0;
      grant_lvl_q <= 1'b0;
      grant_vec_q <= 16'h0000;
    end else if (take_grant) begin
      grant_idx_q <= win_idx;
      grant_lvl_q <= win_lvl;
      grant_vec_q <= win_vec;
    end
  end

  // Flag-clear pulse and nesting level registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clr_flag   <= '0;
      in_service <= 2'b00;
    end else begin
      clr_flag   <= clr_d;
      in_service <= is_d;
    end
  end

endmodule

// File: tb/tb_int_vector_seq.sv
// Bench for int_vector_seq: directed scenarios plus random traffic against a behavioural model.
// Latency: inputs change 2 time units after each rising edge; outputs are checked at the falling edge.
// Backpressure: the bench plays the CPU, acking grants at random or directed times.
module tb_int_vector_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  int_req;
  logic        ea;
  logic [4:0]  ip;
  logic [1:0]  it_mode;
  logic        instr_end;
  logic        blocked;
  logic        cpu_ack;
  logic        reti;
  logic        int_call;
  logic [15:0] int_vector;
  logic [2:0]  int_src;
  logic [4:0]  clr_flag;
  logic [1:0]  in_service;

  int n_cmp = 0;
  int n_bad = 0;

  int_vector_seq dut (
    .clk(clk), .rst_n(rst_n), .int_req(int_req), .ea(ea), .ip(ip),
    .it_mode(it_mode), .instr_end(instr_end), .blocked(blocked),
    .cpu_ack(cpu_ack), .reti(reti), .int_call(int_call),
    .int_vector(int_vector), .int_src(int_src), .clr_flag(clr_flag),
    .in_service(in_service)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic int lowest(input logic [4:0] v);
    for (int i = 0; i < 5; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Behavioural model: a pending grant (source + level), a two-entry in-service stack, a clear pulse.
  bit       m_valid = 0;
  bit       m_call;
  int       m_idx;
  bit       m_lvl;
  bit [1:0] m_is;
  bit [4:0] m_clr;

  always @(posedge clk) begin
    bit       call_n, lvl_n;
    int       idx_n, w;
    bit [1:0] is_n;
    bit [4:0] clr_n, hi, lo;
    call_n = m_call; idx_n = m_idx; lvl_n = m_lvl; is_n = m_is; clr_n = 5'b0;
    if (!rst_n) begin
      call_n = 0; idx_n = 0; lvl_n = 0; is_n = 2'b00;
    end else begin
      if (reti) begin
        if (m_is[1]) is_n[1] = 0;
        else         is_n[0] = 0;
      end
      if (m_call) begin
        if (cpu_ack) begin
          call_n = 0;
          is_n[m_lvl] = 1;
          if (m_idx == 1 || m_idx == 3 ||
              (m_idx == 0 && it_mode[0]) || (m_idx == 2 && it_mode[1]))
            clr_n[m_idx] = 1;
        end
      end else if (instr_end && !blocked && !m_is[1]) begin
        hi = ea ? (int_req & ip) : 5'b0;
        lo = ea ? (int_req & ~ip) : 5'b0;
        w = lowest(hi);
        if (w >= 0) begin
          call_n = 1; idx_n = w; lvl_n = 1;
        end else if (!m_is[0] && lowest(lo) >= 0) begin
          call_n = 1; idx_n = lowest(lo); lvl_n = 0;
        end
      end
    end
    m_call  <= call_n;
    m_idx   <= idx_n;
    m_lvl   <= lvl_n;
    m_is    <= is_n;
    m_clr   <= clr_n;
    m_valid <= 1;
  end

  // Compare every cycle against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model.int_call", int_call, m_call);
      check("model.int_vector", int_vector, m_call ? 16'(3 + 8 * m_idx) : 16'h0);
      check("model.int_src", int_src, m_call ? 16'(m_idx) : 16'h0);
      check("model.clr_flag", clr_flag, m_clr);
      check("model.in_service", in_service, m_is);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    int_req = 0; ea = 1; ip = 0; it_mode = 0;
    instr_end = 0; blocked = 0; cpu_ack = 0; reti = 0;
  endtask

  task automatic pulse_reti();
    reti = 1; tick(); reti = 0;
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    tick(); tick();
    check("reset.int_call", int_call, 0);
    check("reset.int_vector", int_vector, 0);
    check("reset.clr_flag", clr_flag, 0);
    check("reset.in_service", in_service, 0);
    rst_n = 1;
    tick();

    // 1: low T0
    int_req = 5'b00010; instr_end = 1; tick(); instr_end = 0;
    check("t1.int_call", int_call, 1);
    check("t1.int_vector", int_vector, 16'h000B);
    check("t1.int_src", int_src, 1);
    cpu_ack = 1; tick(); cpu_ack = 0; int_req = 0;
    check("t1.ack_call", int_call, 0);
    check("t1.clr_flag", clr_flag, 5'b00010);
    check("t1.in_service", in_service, 2'b01);
    tick();
    check("t1.clr_pulse_end", clr_flag, 0);
    pulse_reti();
    check("t1.reti", in_service, 2'b00);

    // 2: high SERIAL beats low INT0
    int_req = 5'b10001; ip = 5'b10000; instr_end = 1; tick(); instr_end = 0;
    check("t2.int_vector", int_vector, 16'h0023);
    check("t2.int_src", int_src, 4);
    cpu_ack = 1; tick(); cpu_ack = 0; int_req = 0; ip = 0;
    check("t2.in_service", in_service, 2'b10);
    check("t2.clr_flag", clr_flag, 0);
    pulse_reti();
    check("t2.reti", in_service, 2'b00);

    // 3: nesting
    int_req = 5'b00001; instr_end = 1; tick(); instr_end = 0;
    cpu_ack = 1; tick(); cpu_ack = 0; int_req = 0;
    check("t3.lo_is", in_service, 2'b01);
    int_req = 5'b01000; ip = 5'b01000; instr_end = 1; tick(); instr_end = 0;
    check("t3.hi_call", int_call, 1);
    check("t3.hi_vector", int_vector, 16'h001B);
    cpu_ack = 1; tick(); cpu_ack = 0; int_req = 0; ip = 0;
    check("t3.both_is", in_service, 2'b11);
    int_req = 5'b00010; instr_end = 1; tick(); tick();
    check("t3.held_off", int_call, 0);
    pulse_reti();
    check("t3.reti1_is", in_service, 2'b01);
    tick();
    check("t3.still_held", int_call, 0);
    pulse_reti();
    check("t3.reti2_is", in_service, 2'b00);
    check("t3.held_at_reti2", int_call, 0);
    tick(); instr_end = 0;
    check("t3.grant_after", int_call, 1);
    check("t3.grant_src", int_src, 1);
    cpu_ack = 1; tick(); cpu_ack = 0; int_req = 0;
    pulse_reti();

    // 4: blocked boundary
    int_req = 5'b00100; it_mode = 2'b10; instr_end = 1; blocked = 1; tick();
    check("t4.blocked", int_call, 0);
    blocked = 0; tick(); instr_end = 0;
    check("t4.granted", int_call, 1);
    check("t4.vector", int_vector, 16'h0013);
    cpu_ack = 1; tick(); cpu_ack = 0; int_req = 0;
    check("t4.clr_int1_edge", clr_flag, 5'b00100);
    pulse_reti();

    // 5: INT0 level vs edge, request dropping during CALL
    it_mode = 2'b00; int_req = 5'b00001; instr_end = 1; tick(); instr_end = 0; int_req = 0;
    tick();
    check("t5.vector_held", int_vector, 16'h0003);
    check("t5.call_held", int_call, 1);
    cpu_ack = 1; tick(); cpu_ack = 0;
    check("t5.clr_level", clr_flag, 0);
    pulse_reti();
    it_mode = 2'b01; int_req = 5'b00001; instr_end = 1; tick(); instr_end = 0;
    cpu_ack = 1; tick(); cpu_ack = 0; int_req = 0;
    check("t5.clr_edge", clr_flag, 5'b00001);
    pulse_reti();

    // 6: reset mid-CALL
    int_req = 5'b00010; instr_end = 1; tick(); instr_end = 0;
    check("t6.call", int_call, 1);
    rst_n = 0; tick(); rst_n = 1;
    check("t6.rst_call", int_call, 0);
    check("t6.rst_vector", int_vector, 0);
    check("t6.rst_clr", clr_flag, 0);
    int_req = 0; cpu_ack = 1; tick(); cpu_ack = 0;
    check("t6.late_ack_call", int_call, 0);
    check("t6.late_ack_is", in_service, 0);
    check("t6.late_ack_clr", clr_flag, 0);

    // Random traffic, checked by the model every cycle.
    for (int c = 0; c < 4000; c++) begin
      tick();
      int_req   = 5'($urandom);
      ip        = 5'($urandom);
      it_mode   = 2'($urandom);
      ea        = ($urandom_range(0, 9) < 8);
      instr_end = ($urandom_range(0, 9) < 3);
      blocked   = ($urandom_range(0, 9) < 2);
      cpu_ack   = ($urandom_range(0, 9) < 3);
      reti      = ($urandom_range(0, 9) < 1);
      rst_n     = ($urandom_range(0, 199) != 0);
    end
    tick();
    idle_inputs();
    rst_n = 1;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
